// File: rtl/lane_dly_tap_sequencer.sv
// Lane delay-line tap sequencer: frames LOAD/MOVE actions on one RX or TX delay
// line with HS_IO_CLK_PAUSE, paces moves, and tracks both tap positions.
module lane_dly_tap_sequencer #(
    parameter int unsigned MOVE_GAP    = 4,
    parameter int unsigned PAUSE_SETUP = 2,
    parameter int unsigned MAX_TAPS    = 127,
    parameter int unsigned LOAD_TAP    = 1
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_SEL,
    input  logic       CMD_LOAD,
    input  logic       CMD_DIR,
    input  logic [6:0] CMD_STEPS,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DONE,
    output logic       OOR_ERR,
    output logic [6:0] STEPS_DONE,
    output logic [6:0] RX_TAP,
    output logic [6:0] TX_TAP
);

    localparam int unsigned TAP_W = 7;
    localparam int unsigned CNT_W = 4;

    localparam logic [TAP_W-1:0] MAX_TAP_V  = TAP_W'(MAX_TAPS);
    localparam logic [TAP_W-1:0] LOAD_TAP_V = TAP_W'(LOAD_TAP);
    localparam logic [CNT_W-1:0] PAUSE_INIT = CNT_W'(PAUSE_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'((MOVE_GAP > 1) ? (MOVE_GAP - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_LOAD, S_MOVE, S_GAP, S_POST, S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAP_W-1:0]   rem_q, rem_d;
    logic               load_cmd_q, load_cmd_d;
    logic               sel_q, sel_d;
    logic               dir_q, dir_d;
    logic               ready_q, ready_d;
    logic               dload_q, dload_d;
    logic               move_q, move_d;
    logic               pause_q, pause_d;
    logic               done_q, done_d;
    logic               oor_q, oor_d;
    logic [TAP_W-1:0]   steps_q, steps_d;
    logic [TAP_W-1:0]   rx_q, rx_d;
    logic [TAP_W-1:0]   tx_q, tx_d;

    logic [TAP_W-1:0]   tap_sel_c;
    logic [TAP_W-1:0]   tap_nxt_c;
    logic               flag_sel_c;

    function automatic logic at_bound(input logic [TAP_W-1:0] tap, input logic up);
        return up ? (tap == MAX_TAP_V) : (tap == '0);
    endfunction

    // Next state, datapath and registered-output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        load_cmd_d = load_cmd_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        oor_d      = oor_q;
        steps_d    = steps_q;
        rx_d       = rx_q;
        tx_d       = tx_q;

        tap_sel_c  = sel_q ? tx_q : rx_q;
        flag_sel_c = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
        if (dir_q) begin
            tap_nxt_c = (tap_sel_c == MAX_TAP_V) ? tap_sel_c : tap_sel_c + TAP_W'(1);
        end else begin
            tap_nxt_c = (tap_sel_c == '0) ? tap_sel_c : tap_sel_c - TAP_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (ready_q && CMD_VALID) begin
                    state_d    = S_PRE;
                    sel_d      = CMD_SEL;
                    dir_d      = CMD_DIR;
                    rem_d      = CMD_STEPS;
                    load_cmd_d = CMD_LOAD;
                    steps_d    = '0;
                    oor_d      = 1'b0;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    if (load_cmd_q) begin
                        state_d = S_LOAD;
                    end else if (rem_q == '0) begin
                        state_d = S_POST;
                    end else if (at_bound(tap_sel_c, dir_q)) begin
                        oor_d   = 1'b1;
                        state_d = S_POST;
                    end else begin
                        state_d = S_MOVE;
                    end
                end
            end
            S_LOAD: begin
                if (sel_q) tx_d = LOAD_TAP_V;
                else       rx_d = LOAD_TAP_V;
                state_d = S_POST;
            end
            S_MOVE: begin
                if (sel_q) tx_d = tap_nxt_c;
                else       rx_d = tap_nxt_c;
                rem_d   = rem_q - TAP_W'(1);
                steps_d = steps_q + TAP_W'(1);
                // The last move of a command closes the frame without a trailing gap
                if (rem_q == TAP_W'(1)) begin
                    state_d = S_POST;
                end else if (MOVE_GAP > 1) begin
                    state_d = S_GAP;
                end else if (flag_sel_c) begin
                    oor_d   = 1'b1;
                    state_d = S_POST;
                end else if (at_bound(tap_nxt_c, dir_q)) begin
                    oor_d   = 1'b1;
                    state_d = S_POST;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (flag_sel_c) begin
                        oor_d   = 1'b1;
                        state_d = S_POST;
                    end else if (rem_q == '0) begin
                        state_d = S_POST;
                    end else if (at_bound(tap_sel_c, dir_q)) begin
                        oor_d   = 1'b1;
                        state_d = S_POST;
                    end else begin
                        state_d = S_MOVE;
                    end
                end
            end
            S_POST: begin
                if (cnt_q == '0) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Phase counter: reload on entry to a timed state, otherwise count down
        if (state_d != state_q) begin
            if (state_d == S_PRE || state_d == S_POST) cnt_d = PAUSE_INIT;
            else if (state_d == S_GAP)                 cnt_d = GAP_INIT;
            else                                       cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        ready_d = (state_d == S_IDLE);
        dload_d = (state_d == S_LOAD);
        move_d  = (state_d == S_MOVE);
        done_d  = (state_d == S_FIN);
        pause_d = (state_d == S_PRE) || (state_d == S_LOAD) || (state_d == S_MOVE)
               || (state_d == S_GAP) || (state_d == S_POST);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            load_cmd_q <= 1'b0;
            sel_q      <= 1'b0;
            dir_q      <= 1'b0;
            ready_q    <= 1'b0;
            dload_q    <= 1'b0;
            move_q     <= 1'b0;
            pause_q    <= 1'b0;
            done_q     <= 1'b0;
            oor_q      <= 1'b0;
            steps_q    <= '0;
            rx_q       <= LOAD_TAP_V;
            tx_q       <= LOAD_TAP_V;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            load_cmd_q <= load_cmd_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            ready_q    <= ready_d;
            dload_q    <= dload_d;
            move_q     <= move_d;
            pause_q    <= pause_d;
            done_q     <= done_d;
            oor_q      <= oor_d;
            steps_q    <= steps_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
        end
    end

    assign CMD_READY            = ready_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = dload_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DONE                 = done_q;
    assign OOR_ERR              = oor_q;
    assign STEPS_DONE           = steps_q;
    assign RX_TAP               = rx_q;
    assign TX_TAP               = tx_q;

endmodule

// File: tb/tb_lane_dly_tap_sequencer.sv
// Scoreboard bench for lane_dly_tap_sequencer: directed commands push expected
// end-of-command results; a monitor compares them on every DONE pulse.
module tb_lane_dly_tap_sequencer;

    logic       FAB_CLK = 1'b0;
    logic       RESET;
    logic       CMD_VALID, CMD_READY, CMD_SEL, CMD_LOAD, CMD_DIR;
    logic [6:0] CMD_STEPS;
    logic       RX_OOR, TX_OOR;
    logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic       HS_IO_CLK_PAUSE, DONE, OOR_ERR;
    logic [6:0] STEPS_DONE, RX_TAP, TX_TAP;

    lane_dly_tap_sequencer dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .CMD_VALID                  (CMD_VALID),
        .CMD_READY                  (CMD_READY),
        .CMD_SEL                    (CMD_SEL),
        .CMD_LOAD                   (CMD_LOAD),
        .CMD_DIR                    (CMD_DIR),
        .CMD_STEPS                  (CMD_STEPS),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .DONE                       (DONE),
        .OOR_ERR                    (OOR_ERR),
        .STEPS_DONE                 (STEPS_DONE),
        .RX_TAP                     (RX_TAP),
        .TX_TAP                     (TX_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int rx; int tx; int steps; int oor; int moves; int loads; int pause; int sel;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_total = 0;
    int   moves_total = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: per-command activity counters, pulse rules, scoreboard pop on DONE
    int pause_cnt = 0, move_cnt = 0, load_cnt = 0, cyc = 0, last_move = -100;
    always @(negedge FAB_CLK) begin
        cyc++;
        if (RESET) begin
            pause_cnt = 0; move_cnt = 0; load_cnt = 0; last_move = -100;
        end else begin
            if (HS_IO_CLK_PAUSE) pause_cnt++;
            if (DELAY_LINE_MOVE || DELAY_LINE_LOAD)
                chk("move_load_exclusive", int'(DELAY_LINE_MOVE && DELAY_LINE_LOAD), 0);
            if (DELAY_LINE_LOAD) load_cnt++;
            if (DELAY_LINE_MOVE) begin
                chk("move_spacing_ok", int'(cyc - last_move >= 4), 1);
                last_move = cyc;
                move_cnt++;
                moves_total++;
            end
            if (DONE) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE with empty scoreboard (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rx_tap",     int'(RX_TAP),         e.rx);
                    chk("tx_tap",     int'(TX_TAP),         e.tx);
                    chk("steps_done", int'(STEPS_DONE),     e.steps);
                    chk("oor_err",    int'(OOR_ERR),        e.oor);
                    chk("move_count", move_cnt,             e.moves);
                    chk("load_count", load_cnt,             e.loads);
                    chk("pause_cyc",  pause_cnt,            e.pause);
                    chk("line_sel",   int'(DELAY_LINE_SEL), e.sel);
                end
                pause_cnt = 0; move_cnt = 0; load_cnt = 0;
                done_total++;
            end
        end
    end

    task automatic issue(input logic sel, input logic ld, input logic dir, input int steps);
        int n;
        @(negedge FAB_CLK);
        CMD_SEL = sel; CMD_LOAD = ld; CMD_DIR = dir; CMD_STEPS = 7'(steps);
        CMD_VALID = 1'b1;
        n = 0;
        while (!CMD_READY && n < 200) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 0, 1);
        @(posedge FAB_CLK);
        #1 CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_total < target && n < 500) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (n >= 500) chk("done_timeout", done_total, target);
    endtask

    task automatic wait_moves(input int target);
        int n = 0;
        while (moves_total < target && n < 500) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (n >= 500) chk("move_timeout", moves_total, target);
    endtask

    task automatic run(input logic sel, input logic ld, input logic dir, input int steps,
                       input exp_t e);
        int tgt;
        tgt = done_total + 1;
        sb_q.push_back(e);
        issue(sel, ld, dir, steps);
        wait_done(tgt);
    endtask

    initial begin
        int   tgt;
        exp_t e;
        RESET = 1'b1; CMD_VALID = 1'b0; CMD_SEL = 1'b0; CMD_LOAD = 1'b0;
        CMD_DIR = 1'b0; CMD_STEPS = '0; RX_OOR = 1'b0; TX_OOR = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        chk("rst_ready", int'(CMD_READY), 0);
        chk("rst_pause", int'(HS_IO_CLK_PAUSE), 0);
        chk("rst_move",  int'(DELAY_LINE_MOVE), 0);
        chk("rst_load",  int'(DELAY_LINE_LOAD), 0);
        chk("rst_sel",   int'(DELAY_LINE_SEL), 0);
        chk("rst_dir",   int'(DELAY_LINE_DIRECTION), 0);
        chk("rst_done",  int'(DONE), 0);
        chk("rst_oor",   int'(OOR_ERR), 0);
        chk("rst_steps", int'(STEPS_DONE), 0);
        chk("rst_rx",    int'(RX_TAP), 1);
        chk("rst_tx",    int'(TX_TAP), 1);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        chk("ready_after_rst", int'(CMD_READY), 1);

        // Basic move: RX up 3
        e = '{rx:4, tx:1, steps:3, oor:0, moves:3, loads:0, pause:13, sel:0};
        run(1'b0, 1'b0, 1'b1, 3, e);
        // TX up 8 to reach 9
        e = '{rx:4, tx:9, steps:8, oor:0, moves:8, loads:0, pause:33, sel:1};
        run(1'b1, 1'b0, 1'b1, 8, e);
        // TX load back to preset
        e = '{rx:4, tx:1, steps:0, oor:0, moves:0, loads:1, pause:5, sel:1};
        run(1'b1, 1'b1, 1'b0, 50, e);
        // RX load, then decrement 5 from tap 1 hits bound at 0
        e = '{rx:1, tx:1, steps:0, oor:0, moves:0, loads:1, pause:5, sel:0};
        run(1'b0, 1'b1, 1'b1, 0, e);
        e = '{rx:0, tx:1, steps:1, oor:1, moves:1, loads:0, pause:8, sel:0};
        run(1'b0, 1'b0, 1'b0, 5, e);

        // Lane flag after the 2nd pulse of a 6-step command; stray command ignored
        e = '{rx:2, tx:1, steps:2, oor:1, moves:2, loads:0, pause:12, sel:0};
        tgt = done_total + 1;
        sb_q.push_back(e);
        issue(1'b0, 1'b0, 1'b1, 6);
        chk("ready_busy", int'(CMD_READY), 0);
        CMD_SEL = 1'b1; CMD_LOAD = 1'b1; CMD_VALID = 1'b1;
        wait_moves(moves_total + 2);
        RX_OOR = 1'b1;
        CMD_VALID = 1'b0;
        wait_done(tgt);
        RX_OOR = 1'b0;
        repeat (4) @(negedge FAB_CLK);
        chk("no_stray_done", done_total, tgt);

        // Reset in the middle of a gap of a 10-step command
        issue(1'b0, 1'b0, 1'b1, 10);
        wait_moves(moves_total + 2);
        @(negedge FAB_CLK);
        RESET = 1'b1;
        @(negedge FAB_CLK);
        chk("midrst_pause", int'(HS_IO_CLK_PAUSE), 0);
        chk("midrst_move",  int'(DELAY_LINE_MOVE), 0);
        chk("midrst_rx",    int'(RX_TAP), 1);
        chk("midrst_tx",    int'(TX_TAP), 1);
        chk("midrst_ready", int'(CMD_READY), 0);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        chk("midrst_ready_after", int'(CMD_READY), 1);

        // Zero-step command: pause frame only
        e = '{rx:1, tx:1, steps:0, oor:0, moves:0, loads:0, pause:4, sel:1};
        run(1'b1, 1'b0, 1'b1, 0, e);

        repeat (3) @(negedge FAB_CLK);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
